clock_control: RTL and testbench
================================

Name: clock_control

Overview:
- Parametrised successor to the board clock pause/run block.
- Runs on the single board oscillator and produces a glitch-free one-cycle clock-enable, cpu_clk_en, for the CPU datapath instead of a gated clock.
- Adds button synchronisation and debounce, a programmable divider, single-step and N-cycle burst modes, halt-stop, and a retired-cycle counter.
- Sits between the board pushbuttons/switches and every CPU register's enable input.

Parameters:
- DIV_WIDTH, 24, width of div_ratio and the divider counter.
- DEBOUNCE_CYCLES, 50000, number of stable sampled cycles before a button level is accepted (bench uses 4).
- BURST_WIDTH, 8, width of burst_len and the burst counter.
- COUNT_WIDTH, 32, width of cycle_count.

Ports:
- clk_in  input  1  board oscillator; the only clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start_button  input  1  active-low pushbuttonanually; asynchronous to clk_in.
- step_button  input  1  active-low pushbutton; asynchronous.
- manual_clock  input  1  mode switch: 0 = manual/step mode, 1 = free-run mode; asynchronous.
- halt_in  input  1  CPU halt request, synchronous to clk_in.
- div_ratio  input  DIV_WIDTH  enable period in clk_in cycles, minus one.
- burst_len  input  BURST_WIDTH  number of enables per burst.
- cpu_clk_en  output  1  one-cycle enable pulse to the CPU.
- running  output  1  high while in RUN or BURST.
- cycle_count  output  COUNT_WIDTH  total cpu_clk_en pulses since reset.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; cpu_clk_en=0; running=0; cycle_count=0; divider, burst counter, synchronisers and debouncers cleared; debounced button levels set to released (1).
- Input conditioning:
  - start_button, step_button and manual_clock each pass through a 2-flop synchroniser.
  - Each button then passes through a debouncer. The accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A press event is a 1->0 transition of the accepted level, lasting one cycle.
  - Latency from a stable button edge to its press event: 2 + DEBOUNCE_CYCLES cycles.
- Divider:
  - Counts 0..div_ratio while running, producing tick when count == div_ratio, then wraps to 0.
  - div_ratio=0 gives a tick every cycle.
  - Counter clears on every entry to RUN or BURST, so the first tick occurs div_ratio+1 cycles after entry.
  - A div_ratio change takes effect at the next wrap. If the new value is below the current count, the counter wraps at its maximum value (no special handling).
- States: IDLE, RUN, STEP, BURST.
  - IDLE, manual_clock=1, start press -> RUN.
  - IDLE, manual_clock=0, start press -> STEP.
  - IDLE, manual_clock=0, step press, burst_len != 0 -> BURST, loading the burst counter with burst_len.
  - IDLE, step press with burst_len == 0 -> ignored.
  - STEP: cpu_clk_en=1 for exactly one cycle, then -> IDLE (no divider).
  - RUN: cpu_clk_en = tick. Start press -> IDLE.
  - BURST: cpu_clk_en = tick. Each tick decrements the burst counter; the tick that takes it to 0 is emitted, then -> IDLE. A start press aborts to IDLE.
- Priority (highest first), applied in every state:
  1. halt_in=1 -> IDLE with no enable that cycle.
  2. Synchronised manual_clock differs from its previous value -> IDLE.
  3. Start press.
  4. Step press.
- Simultaneous start and step presses: start wins; the step press is dropped.
- Step presses in RUN or BURST are ignored.
- halt_in held high keeps the block in IDLE; presses are ignored until it falls.
- running = (state==RUN or state==BURST); registered, updates with the state.
- cpu_clk_en is registered and never high for two consecutive cycles unless div_ratio=0 in RUN or BURST.
- cycle_count increments on every cycle with cpu_clk_en=1 and wraps modulo 2^COUNT_WIDTH.
- Reset asserted mid-burst or mid-run: immediate IDLE, no residual pulse after release.

Decomposition:
- Shared package clock_ctrl_pkg holds:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, STEP=2'd2, BURST=2'd3.
  - Default parameter values.
- One sub-module, button_debounce: synchroniser plus debouncer plus falling-edge detector, parametrised by DEBOUNCE_CYCLES, with output press_evt. Instantiated twice (start and step).
- manual_clock uses the synchroniser only.

Test Plan:
- Reset with buttons released -> cpu_clk_en=0, running=0, cycle_count=0. Release reset -> outputs unchanged for 100 cycles.
- manual_clock=1, div_ratio=3, start press -> running=1 at press event + 1. Enables then occur every 4 cycles; after 10 enables cycle_count=10. Second start press -> running=0, no further enables.
- manual_clock=0, start press held 20 cycles with 3-cycle bounce at each edge -> exactly one cpu_clk_en pulse, cycle_count=1.
- manual_clock=0, burst_len=5, div_ratio=0, step press -> exactly 5 consecutive enables, then running=0 and cycle_count=5. Repeat with burst_len=0 -> no enables.
- RUN with div_ratio=1, assert halt_in for one cycle -> IDLE that cycle with no enable in the halt cycle. Also toggle manual_clock during BURST -> IDLE, burst abandoned.
- Assert reset mid-BURST after 2 of 8 enables -> immediate IDLE, cycle_count=0, no enable after reset release.

Source files
------------

// File: rtl/clock_control_pkg.sv
// -----------------------------------------------------------------------------
// clock_ctrl_pkg
// Shared definitions for the CPU clock-enable controller: the state encoding
// used by the controller FSM and the default parameter values used by the
// top level and the button conditioning sub-module.
// -----------------------------------------------------------------------------
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        BURST = 2'd3
    } state_t;

    localparam int DEF_DIV_WIDTH       = 24;
    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_BURST_WIDTH     = 8;
    localparam int DEF_COUNT_WIDTH     = 32;

endpackage

// File: rtl/clock_control_button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Conditions one active-low asynchronous pushbutton: 2-flop synchroniser,
// debouncer that accepts a new level only after DEBOUNCE_CYCLES consecutive
// equal samples, and a one-cycle press event on a 1->0 accepted transition.
// Ports:
//   clk_in    board clock
//   reset     asynchronous active-low reset
//   button    raw pushbutton level (0 = pressed)
//   press_evt registered one-cycle pulse when a press is accepted
// -----------------------------------------------------------------------------
module button_debounce
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
    input  logic clk_in,
    input  logic reset,
    input  logic button,
    output logic press_evt
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchroniser; resets to the released level so no false edge follows reset.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= button;
            sync2_r <= sync1_r;
        end
    end

    // Debouncer: any sample equal to the accepted level restarts the count.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            level_r <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
            press_r <= 1'b0;
        end else if (sync2_r == level_r) begin
            cnt_r   <= {CNT_W{1'b0}};
            press_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            level_r <= sync2_r;
            cnt_r   <= {CNT_W{1'b0}};
            press_r <= ~sync2_r;
        end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            press_r <= 1'b0;
        end
    end

    assign press_evt = press_r;

endmodule

// File: rtl/clock_control.sv
// -----------------------------------------------------------------------------
// clock_control
// Generates a glitch-free one-cycle clock enable for the CPU datapath from the
// board oscillator, with free-run, single-step and N-cycle burst modes, a
// programmable divider, halt-stop and a retired-cycle counter.
// Ports:
//   clk_in        board oscillator (only clock)
//   reset         asynchronous active-low reset
//   start_button  active-low pushbutton, asynchronous
//   step_button   active-low pushbutton, asynchronous
//   manual_clock  mode switch, 0 = step/burst, 1 = free-run; asynchronous
//   halt_in       CPU halt request, synchronous
//   div_ratio     enable period in clk_in cycles minus one
//   burst_len     enables per burst
//   cpu_clk_en    registered one-cycle enable to the CPU
//   running       registered, high in RUN or BURST
//   cycle_count   number of enables since reset (wraps)
// -----------------------------------------------------------------------------
module clock_control
    import clock_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH       = DEF_DIV_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int BURST_WIDTH     = DEF_BURST_WIDTH,
    parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH
)(
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   start_button,
    input  logic                   step_button,
    input  logic                   manual_clock,
    input  logic                   halt_in,
    input  logic [DIV_WIDTH-1:0]   div_ratio,
    input  logic [BURST_WIDTH-1:0] burst_len,
    output logic                   cpu_clk_en,
    output logic                   running,
    output logic [COUNT_WIDTH-1:0] cycle_count
);

    state_t                 state_r;
    logic                   en_r;
    logic                   running_r;
    logic [DIV_WIDTH-1:0]   div_cnt_r;
    logic [BURST_WIDTH-1:0] burst_cnt_r;
    logic [COUNT_WIDTH-1:0] count_r;
    logic                   man_sync1_r;
    logic                   man_sync2_r;
    logic                   man_prev_r;
    logic                   start_evt_s;
    logic                   step_evt_s;
    logic                   tick_s;
    logic                   mode_chg_s;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk_in    (clk_in),
        .reset     (reset),
        .button    (start_button),
        .press_evt (start_evt_s)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk_in    (clk_in),
        .reset     (reset),
        .button    (step_button),
        .press_evt (step_evt_s)
    );

    // Mode switch synchroniser plus one-cycle history for change detection.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            man_sync1_r <= 1'b0;
            man_sync2_r <= 1'b0;
            man_prev_r  <= 1'b0;
        end else begin
            man_sync1_r <= manual_clock;
            man_sync2_r <= man_sync1_r;
            man_prev_r  <= man_sync2_r;
        end
    end

    assign mode_chg_s = man_sync2_r ^ man_prev_r;
    // Equality against the live ratio: a lowered ratio below the current
    // count is only reached after the counter wraps at its maximum.
    assign tick_s     = (div_cnt_r == div_ratio);

    // Controller FSM with divider, burst counter and registered outputs.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            running_r   <= 1'b0;
            en_r        <= 1'b0;
            div_cnt_r   <= {DIV_WIDTH{1'b0}};
            burst_cnt_r <= {BURST_WIDTH{1'b0}};
        end else begin
            en_r <= 1'b0;
            if (halt_in || mode_chg_s) begin
                state_r   <= IDLE;
                running_r <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start_evt_s) begin
                            div_cnt_r <= {DIV_WIDTH{1'b0}};
                            if (man_sync2_r) begin
                                state_r   <= RUN;
                                running_r <= 1'b1;
                            end else begin
                                state_r   <= STEP;
                                running_r <= 1'b0;
                            end
                        end else if (step_evt_s && !man_sync2_r &&
                                     (burst_len != {BURST_WIDTH{1'b0}})) begin
                            state_r     <= BURST;
                            running_r   <= 1'b1;
                            burst_cnt_r <= burst_len;
                            div_cnt_r   <= {DIV_WIDTH{1'b0}};
                        end else begin
                            state_r   <= IDLE;
                            running_r <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (start_evt_s) begin
                            state_r   <= IDLE;
                            running_r <= 1'b0;
                        end else if (tick_s) begin
                            en_r      <= 1'b1;
                            div_cnt_r <= {DIV_WIDTH{1'b0}};
                        end else begin
                            div_cnt_r <= div_cnt_r + DIV_WIDTH'(1);
                        end
                    end
                    STEP: begin
                        en_r      <= 1'b1;
                        state_r   <= IDLE;
                        running_r <= 1'b0;
                    end
                    BURST: begin
                        if (start_evt_s) begin
                            state_r   <= IDLE;
                            running_r <= 1'b0;
                        end else if (tick_s) begin
                            en_r        <= 1'b1;
                            div_cnt_r   <= {DIV_WIDTH{1'b0}};
                            burst_cnt_r <= burst_cnt_r - BURST_WIDTH'(1);
                            // Last enable of the burst leaves together with the pulse.
                            if (burst_cnt_r == BURST_WIDTH'(1)) begin
                                state_r   <= IDLE;
                                running_r <= 1'b0;
                            end else begin
                                state_r   <= BURST;
                                running_r <= 1'b1;
                            end
                        end else begin
                            div_cnt_r <= div_cnt_r + DIV_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        running_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Retired-cycle counter, wraps naturally at its width.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            count_r <= {COUNT_WIDTH{1'b0}};
        end else if (en_r) begin
            count_r <= count_r + COUNT_WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign cpu_clk_en  = en_r;
    assign running     = running_r;
    assign cycle_count = count_r;

endmodule

// File: tb/tb_clock_control.sv
// -----------------------------------------------------------------------------
// tb_clock_control
// Scenario tasks drive the pushbuttons/switches and compare enable timing,
// running and cycle_count against values computed from the block's rules:
// press latency 2+DEBOUNCE_CYCLES, entry one cycle later, enables every
// div_ratio+1 cycles after entry.
// -----------------------------------------------------------------------------
module tb_clock_control;

    localparam int DW        = 24;
    localparam int DB        = 4;
    localparam int BW        = 8;
    localparam int CW        = 32;
    localparam int PRESS_LAT = 2 + DB;

    logic          clk_in = 1'b0;
    logic          reset;
    logic          start_button;
    logic          step_button;
    logic          manual_clock;
    logic          halt_in;
    logic [DW-1:0] div_ratio;
    logic [BW-1:0] burst_len;
    logic          cpu_clk_en;
    logic          running;
    logic [CW-1:0] cycle_count;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            en_q[$];
    logic [CW-1:0] model_count;

    clock_control #(
        .DIV_WIDTH       (DW),
        .DEBOUNCE_CYCLES (DB),
        .BURST_WIDTH     (BW),
        .COUNT_WIDTH     (CW)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .start_button (start_button),
        .step_button  (step_button),
        .manual_clock (manual_clock),
        .halt_in      (halt_in),
        .div_ratio    (div_ratio),
        .burst_len    (burst_len),
        .cpu_clk_en   (cpu_clk_en),
        .running      (running),
        .cycle_count  (cycle_count)
    );

    always #5 clk_in = ~clk_in;

    // Rising-edge index: an enable seen after edge N is recorded as N.
    always @(posedge clk_in) cyc <= cyc + 1;

    // Enable monitor
    always @(negedge clk_in) begin
        if (reset === 1'b1 && cpu_clk_en === 1'b1) en_q.push_back(cyc);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start_button = 1'b1; step_button = 1'b1;
        manual_clock = 1'b0; halt_in = 1'b0;
        div_ratio = DW'(0); burst_len = BW'(0);
        model_count = 32'd0;
        tick(3);
        total++; if (cpu_clk_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b want=0", cpu_clk_en); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b want=0", running); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", cycle_count); end
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            total++;
            if (cpu_clk_en !== 1'b0 || running !== 1'b0 || cycle_count !== 32'd0) begin
                bad++;
                $display("FAIL post_reset_idle got=en%b/run%b/cnt%0d want=0/0/0", cpu_clk_en, running, cycle_count);
            end
        end
    endtask

    task automatic test_run(input int div, input int stop_after);
        int c0, c1, entry, period, exp_n, w;
        manual_clock = 1'b1; div_ratio = DW'(div); period = div + 1;
        tick(10); en_q.delete();
        start_button = 1'b0; c0 = cyc; entry = c0 + PRESS_LAT + 1;
        tick(PRESS_LAT);
        total++; if (running !== 1'b0) begin bad++; $display("FAIL run_pre_entry got=%b want=0", running); end
        tick(1);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL run_entry got=%b want=1", running); end
        tick(3); start_button = 1'b1;
        tick(PRESS_LAT + 4);
        w = 0;
        while (en_q.size() < stop_after && w < 500) begin tick(1); w++; end
        total++; if (en_q.size() < stop_after) begin bad++; $display("FAIL run_wait got=%0d want=%0d", en_q.size(), stop_after); end
        tick(1);
        exp_n = (cyc - 1 - entry) / period;
        total++;
        if (cycle_count !== model_count + 32'(exp_n)) begin
            bad++; $display("FAIL run_count got=%0d want=%0d", cycle_count, model_count + 32'(exp_n));
        end
        for (int k = 0; k < stop_after && k < en_q.size(); k++) begin
            total++;
            if (en_q[k] !== entry + period * (k + 1)) begin
                bad++; $display("FAIL run_time k=%0d got=%0d want=%0d", k, en_q[k], entry + period * (k + 1));
            end
        end
        start_button = 1'b0; c1 = cyc;
        tick(10); start_button = 1'b1; tick(30);
        exp_n = (c1 + PRESS_LAT - entry) / period;
        model_count = model_count + 32'(exp_n);
        total++; if (en_q.size() !== exp_n) begin bad++; $display("FAIL run_total got=%0d want=%0d", en_q.size(), exp_n); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL run_stop got=%b want=0", running); end
        total++; if (cycle_count !== model_count) begin bad++; $display("FAIL run_final_count got=%0d want=%0d", cycle_count, model_count); end
    endtask

    task automatic test_bounce();
        manual_clock = 1'b0; tick(10); en_q.delete();
        start_button = 1'b0; tick(1); start_button = 1'b1; tick(1);
        start_button = 1'b0; tick(20);
        start_button = 1'b1; tick(1); start_button = 1'b0; tick(1);
        start_button = 1'b1; tick(20);
        model_count = model_count + 32'd1;
        total++; if (en_q.size() !== 1) begin bad++; $display("FAIL bounce_pulses got=%0d want=1", en_q.size()); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL bounce_running got=%b want=0", running); end
        total++; if (cycle_count !== model_count) begin bad++; $display("FAIL bounce_count got=%0d want=%0d", cycle_count, model_count); end
    endtask

    task automatic test_burst(input int len, input int div);
        int c0, entry, rest;
        manual_clock = 1'b0; burst_len = BW'(len); div_ratio = DW'(div);
        tick(10); en_q.delete();
        step_button = 1'b0; c0 = cyc; entry = c0 + PRESS_LAT + 1;
        tick(10); step_button = 1'b1;
        rest = PRESS_LAT + 1 + (div + 1) * len - 10;
        if (rest > 0) tick(rest);
        tick(5);
        model_count = model_count + 32'(len);
        total++; if (en_q.size() !== len) begin bad++; $display("FAIL burst_len got=%0d want=%0d", en_q.size(), len); end
        for (int k = 0; k < len && k < en_q.size(); k++) begin
            total++;
            if (en_q[k] !== entry + (div + 1) * (k + 1)) begin
                bad++; $display("FAIL burst_time k=%0d got=%0d want=%0d", k, en_q[k], entry + (div + 1) * (k + 1));
            end
        end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL burst_done got=%b want=0", running); end
        total++; if (cycle_count !== model_count) begin bad++; $display("FAIL burst_count got=%0d want=%0d", cycle_count, model_count); end
    endtask

    task automatic test_halt_pulse();
        int c0, h;
        manual_clock = 1'b1; div_ratio = DW'(1); tick(10); en_q.delete();
        start_button = 1'b0; c0 = cyc;
        tick(10); start_button = 1'b1;
        h = c0 + PRESS_LAT + 1 + 2 * 5;
        while (cyc < h - 1) tick(1);
        halt_in = 1'b1; tick(1);
        total++; if (cpu_clk_en !== 1'b0) begin bad++; $display("FAIL halt_no_en got=%b want=0", cpu_clk_en); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL halt_idle got=%b want=0", running); end
        halt_in = 1'b0; tick(20);
        model_count = model_count + 32'd4;
        total++; if (en_q.size() !== 4) begin bad++; $display("FAIL halt_pulses got=%0d want=4", en_q.size()); end
        total++; if (cycle_count !== model_count) begin bad++; $display("FAIL halt_count got=%0d want=%0d", cycle_count, model_count); end
    endtask

    task automatic test_mode_toggle_burst();
        manual_clock = 1'b0; div_ratio = DW'(9); burst_len = BW'(20);
        tick(10); en_q.delete();
        step_button = 1'b0; tick(10); step_button = 1'b1; tick(10);
        manual_clock = 1'b1; tick(40);
        model_count = model_count + 32'd1;
        total++; if (en_q.size() !== 1) begin bad++; $display("FAIL toggle_pulses got=%0d want=1", en_q.size()); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL toggle_idle got=%b want=0", running); end
        total++; if (cycle_count !== model_count) begin bad++; $display("FAIL toggle_count got=%0d want=%0d", cycle_count, model_count); end
        manual_clock = 1'b0; tick(10);
    endtask

    task automatic test_halt_hold();
        halt_in = 1'b1; manual_clock = 1'b1; div_ratio = DW'(0);
        tick(10); en_q.delete();
        start_button = 1'b0; tick(10); start_button = 1'b1; tick(20);
        total++; if (running !== 1'b0 || en_q.size() !== 0) begin bad++; $display("FAIL halt_hold got=run%b/%0d want=0/0", running, en_q.size()); end
        halt_in = 1'b0; tick(20);
        total++; if (running !== 1'b0 || en_q.size() !== 0) begin bad++; $display("FAIL halt_release got=run%b/%0d want=0/0", running, en_q.size()); end
        manual_clock = 1'b0; tick(10);
    endtask

    task automatic test_simultaneous();
        int c0;
        manual_clock = 1'b0; burst_len = BW'(4); div_ratio = DW'(0);
        tick(10); en_q.delete();
        start_button = 1'b0; step_button = 1'b0; c0 = cyc;
        tick(10); start_button = 1'b1; step_button = 1'b1; tick(20);
        model_count = model_count + 32'd1;
        total++; if (en_q.size() !== 1) begin bad++; $display("FAIL simul_pulses got=%0d want=1", en_q.size()); end
        if (en_q.size() > 0) begin
            total++; if (en_q[0] !== c0 + PRESS_LAT + 2) begin bad++; $display("FAIL simul_time got=%0d want=%0d", en_q[0], c0 + PRESS_LAT + 2); end
        end
        total++; if (cycle_count !== model_count) begin bad++; $display("FAIL simul_count got=%0d want=%0d", cycle_count, model_count); end
    endtask

    task automatic test_reset_mid_burst();
        int w;
        manual_clock = 1'b0; burst_len = BW'(8); div_ratio = DW'(3);
        tick(10); en_q.delete();
        step_button = 1'b0; tick(10); step_button = 1'b1;
        w = 0;
        while (en_q.size() < 2 && w < 200) begin tick(1); w++; end
        total++; if (en_q.size() < 2) begin bad++; $display("FAIL rst_wait got=%0d want=2", en_q.size()); end
        reset = 1'b0; #1;
        model_count = 32'd0;
        total++; if (cpu_clk_en !== 1'b0) begin bad++; $display("FAIL rst_mid_en got=%b want=0", cpu_clk_en); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL rst_mid_running got=%b want=0", running); end
        total++; if (cycle_count !== model_count) begin bad++; $display("FAIL rst_mid_count got=%0d want=0", cycle_count); end
        tick(3); reset = 1'b1; en_q.delete(); tick(60);
        total++; if (en_q.size() !== 0) begin bad++; $display("FAIL rst_residual got=%0d want=0", en_q.size()); end
        total++; if (running !== 1'b0 || cycle_count !== 32'd0) begin bad++; $display("FAIL rst_after got=run%b/cnt%0d want=0/0", running, cycle_count); end
    endtask

    initial begin
        test_reset();
        test_run(3, 10);
        test_bounce();
        test_burst(5, 0);
        test_burst(0, 0);
        test_halt_pulse();
        test_mode_toggle_burst();
        test_halt_hold();
        test_simultaneous();
        for (int it = 0; it < 4; it++) begin
            test_run(int'($urandom_range(4, 0)), int'($urandom_range(6, 1)));
        end
        for (int it = 0; it < 4; it++) begin
            test_burst(int'($urandom_range(10, 1)), int'($urandom_range(3, 0)));
        end
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
